// File: rtl/fc_l2_arb_pkg.sv
// Shared types and the round-robin pick helper for the FC L2 port arbiter.
package fc_l2_arb_pkg;

    localparam int unsigned N_MASTER_MAX = 8;
    localparam int unsigned CNT_W        = 32;

    typedef logic [$clog2(N_MASTER_MAX)-1:0] id_t;

    typedef struct packed {
        logic valid;
        id_t  id;
    } rr_pick_t;

    // First asserted request at or after ptr, scanning upward and wrapping at n_master.
    function automatic rr_pick_t rr_pick(input logic [N_MASTER_MAX-1:0] req,
                                         input id_t                     ptr,
                                         input int unsigned             n_master);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < N_MASTER_MAX; k++) begin
            idx = (32'(ptr) + k) % n_master;
            if (k < n_master && !res.valid && req[id_t'(idx)]) begin
                res.valid = 1'b1;
                res.id    = id_t'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// Circular FIFO of requester IDs for granted-but-unanswered L2 transactions.
// A push is accepted while full when a pop happens in the same cycle.
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  id_t                        push_id_i,
    input  logic                       pop_i,
    output id_t                        head_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    id_t            mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Depth is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/fc_l2_port_arbiter_id_fifo.sv
// Thin wrapper kept for the codebase layout; the ID FIFO lives in fc_l2_arb_id_fifo.
module fc_l2_port_arbiter_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  id_t                        push_id_i,
    input  logic                       pop_i,
    output id_t                        head_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    fc_l2_arb_id_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_i),
        .push_id_i (push_id_i),
        .pop_i     (pop_i),
        .head_o    (head_o),
        .count_o   (count_o),
        .full_o    (full_o),
        .empty_o   (empty_o)
    );

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port among N_MASTER requesters.
// Optional per-master grant counters are built when FC_L2_ARB_PERF_EN is defined.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTER        = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    localparam int unsigned BE_W           = DATA_W / 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_MASTER-1:0]                m_req_i,
    input  logic [N_MASTER-1:0][ADDR_W-1:0]    m_add_i,
    input  logic [N_MASTER-1:0]                m_wen_i,
    input  logic [N_MASTER-1:0][DATA_W-1:0]    m_wdata_i,
    input  logic [N_MASTER-1:0][BE_W-1:0]      m_be_i,
    output logic [N_MASTER-1:0]                m_gnt_o,
    output logic [N_MASTER-1:0]                m_r_valid_o,
    output logic [DATA_W-1:0]                  m_r_rdata_o,
    output logic                               m_r_opc_o,
    output logic                               s_req_o,
    output logic [ADDR_W-1:0]                  s_add_o,
    output logic                               s_wen_o,
    output logic [DATA_W-1:0]                  s_wdata_o,
    output logic [BE_W-1:0]                    s_be_o,
    input  logic                               s_gnt_i,
    input  logic                               s_r_valid_i,
    input  logic [DATA_W-1:0]                  s_r_rdata_i,
    input  logic                               s_r_opc_i,
    output logic                               busy_o,
    output logic                               err_o,
    output logic [N_MASTER-1:0][CNT_W-1:0]     grant_cnt_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING+1);

    id_t                     rr_ptr_q, rr_ptr_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [N_MASTER_MAX-1:0] req_pad;
    rr_pick_t                pick;
    logic                    can_issue;
    logic                    grant;
    logic                    pop;
    id_t                     head;
    logic [CntW-1:0]         count;
    logic [CntW-1:0]         count_nxt;
    logic                    full;
    logic                    empty;

    fc_l2_arb_id_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (grant),
        .push_id_i (pick.id),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        req_pad                 = '0;
        req_pad[N_MASTER-1:0]   = m_req_i;
        pick                    = rr_pick(req_pad, rr_ptr_q, N_MASTER);
    end

    // A response in the same cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = ~full | s_r_valid_i;
    assign s_req_o   = pick.valid & can_issue & ~rst_i;
    assign grant     = s_req_o & s_gnt_i;
    assign pop       = s_r_valid_i & ~empty;

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_opc_o   = s_r_opc_i;

    always_comb begin
        s_add_o     = '0;
        s_wen_o     = 1'b0;
        s_wdata_o   = '0;
        s_be_o      = '0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (pick.valid && pick.id == id_t'(i)) begin
                s_add_o    = m_add_i[i];
                s_wen_o    = m_wen_i[i];
                s_wdata_o  = m_wdata_i[i];
                s_be_o     = m_be_i[i];
                m_gnt_o[i] = grant;
            end
            if (pop && head == id_t'(i)) begin
                m_r_valid_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (pick.id == id_t'(N_MASTER-1)) ? '0 : pick.id + id_t'(1);
        end
    end

    // A response with nothing outstanding is a protocol violation and is dropped.
    assign err_d     = err_q | (s_r_valid_i & empty);
    assign count_nxt = count + CntW'(grant) - CntW'(pop);
    assign busy_d    = (count_nxt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

`ifdef FC_L2_ARB_PERF_EN
    logic [N_MASTER-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (m_gnt_o[i] && grant_cnt_q[i] != {CNT_W{1'b1}}) begin
                grant_cnt_d[i] = grant_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Randomised and directed bench for fc_l2_port_arbiter with a queue-based reference model
// and a response scoreboard.
module tb_fc_l2_port_arbiter;

    localparam int N    = 3;
    localparam int MAXO = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_i;
    logic [N-1:0]             m_req_i;
    logic [N-1:0][AW-1:0]     m_add_i;
    logic [N-1:0]             m_wen_i;
    logic [N-1:0][DW-1:0]     m_wdata_i;
    logic [N-1:0][BW-1:0]     m_be_i;
    logic [N-1:0]             m_gnt_o;
    logic [N-1:0]             m_r_valid_o;
    logic [DW-1:0]            m_r_rdata_o;
    logic                     m_r_opc_o;
    logic                     s_req_o;
    logic [AW-1:0]            s_add_o;
    logic                     s_wen_o;
    logic [DW-1:0]            s_wdata_o;
    logic [BW-1:0]            s_be_o;
    logic                     s_gnt_i;
    logic                     s_r_valid_i;
    logic [DW-1:0]            s_r_rdata_i;
    logic                     s_r_opc_i;
    logic                     busy_o;
    logic                     err_o;
    logic [N-1:0][31:0]       grant_cnt_o;

    fc_l2_port_arbiter #(
        .N_MASTER        (N),
        .MAX_OUTSTANDING (MAXO),
        .ADDR_W          (AW),
        .DATA_W          (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m_req_i     (m_req_i),
        .m_add_i     (m_add_i),
        .m_wen_i     (m_wen_i),
        .m_wdata_i   (m_wdata_i),
        .m_be_i      (m_be_i),
        .m_gnt_o     (m_gnt_o),
        .m_r_valid_o (m_r_valid_o),
        .m_r_rdata_o (m_r_rdata_o),
        .m_r_opc_o   (m_r_opc_o),
        .s_req_o     (s_req_o),
        .s_add_o     (s_add_o),
        .s_wen_o     (s_wen_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_gnt_i     (s_gnt_i),
        .s_r_valid_i (s_r_valid_i),
        .s_r_rdata_i (s_r_rdata_i),
        .s_r_opc_i   (s_r_opc_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .grant_cnt_o (grant_cnt_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         exp_q[$];   // scoreboard: expected responses in issue order
    logic [AW-1:0] l2_q[$];    // addresses the emulated L2 still owes a response for

    // Reference model state
    int           rr_m;
    int           cnt_m;
    bit           err_m;
    longint       gcnt_m[N];
    logic [N-1:0] gnt_last;
    int           nxt_w;
    logic [N-1:0] nxt_gnt;
    bit           nxt_pop;
    bit           nxt_spur;
    logic [AW-1:0] nxt_addr;

    // Driver knobs (percent probabilities)
    logic [N-1:0] mask;
    int           req_p;
    int           gnt_p;
    int           rv_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] resp_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d        = 32'hA0 + {29'b0, a[10:8]};
        d[23:16] = a[7:0];
        return d;
    endfunction

    function automatic logic [AW-1:0] gen_addr(input int i);
        return 32'h1C00_0000 | (32'(i) << 8) | ($urandom & 32'hFC);
    endfunction

    function automatic longint exp_cnt(input int i);
`ifdef FC_L2_ARB_PERF_EN
        return gcnt_m[i];
`else
        return (i < 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    task automatic clear_model();
        rr_m     = 0;
        cnt_m    = 0;
        err_m    = 0;
        gnt_last = '0;
        nxt_gnt  = '0;
        nxt_pop  = 0;
        nxt_spur = 0;
        nxt_w    = -1;
        for (int i = 0; i < N; i++) gcnt_m[i] = 0;
        exp_q.delete();
        l2_q.delete();
    endtask

    // Model evaluation at the negative edge, when inputs and combinational outputs are stable.
    initial begin
        int            w;
        int            m;
        bit            can;
        bit            sreq;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        logic [BW-1:0] eb;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    m = (rr_m + k) % N;
                    if (w < 0 && m_req_i[m]) w = m;
                end
                can  = (cnt_m < MAXO) || s_r_valid_i;
                sreq = (w >= 0) && can;
                eg = '0; ea = '0; ew = 1'b0; ed = '0; eb = '0;
                if (w >= 0) begin
                    ea = m_add_i[w];
                    ew = m_wen_i[w];
                    ed = m_wdata_i[w];
                    eb = m_be_i[w];
                    if (sreq && s_gnt_i) eg[w] = 1'b1;
                end
                chk("s_req_o", 64'(s_req_o), 64'(sreq));
                chk("m_gnt_o", 64'(m_gnt_o), 64'(eg));
                chk("s_add_o", 64'(s_add_o), 64'(ea));
                chk("s_wen_o", 64'(s_wen_o), 64'(ew));
                chk("s_wdata_o", 64'(s_wdata_o), 64'(ed));
                chk("s_be_o", 64'(s_be_o), 64'(eb));
                chk("busy_o", 64'(busy_o), 64'(cnt_m != 0));
                chk("err_o", 64'(err_o), 64'(err_m));
                for (int i = 0; i < N; i++) chk("grant_cnt_o", 64'(grant_cnt_o[i]), exp_cnt(i));
                nxt_gnt  = eg;
                nxt_w    = w;
                nxt_addr = ea;
                nxt_pop  = s_r_valid_i && cnt_m > 0;
                nxt_spur = s_r_valid_i && cnt_m == 0;
            end
        end
    end

    // Model state commit at the active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_i) begin
                if (nxt_gnt != '0) begin
                    rr_m = (nxt_w + 1) % N;
                    cnt_m++;
                    exp_q.push_back('{id: nxt_w, data: resp_data(nxt_addr)});
                    l2_q.push_back(nxt_addr);
                    if (gcnt_m[nxt_w] < 64'hFFFF_FFFF) gcnt_m[nxt_w]++;
                end
                if (nxt_pop) cnt_m--;
                if (nxt_spur) err_m = 1;
                gnt_last = nxt_gnt;
                nxt_gnt  = '0;
                nxt_pop  = 0;
                nxt_spur = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever L2 presents a response.
    initial begin
        resp_t        e;
        logic [N-1:0] ev;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (s_r_valid_i && exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    ev = '0;
                    ev[e.id] = 1'b1;
                    chk("m_r_valid_o", 64'(m_r_valid_o), 64'(ev));
                    chk("m_r_rdata_o", 64'(m_r_rdata_o), 64'(e.data));
                    chk("m_r_opc_o", 64'(m_r_opc_o), 64'(s_r_opc_i));
                end else begin
                    chk("m_r_valid_idle", 64'(m_r_valid_o), 64'd0);
                end
            end
        end
    end

    task automatic step();
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_req_i[i] && !gnt_last[i]) begin
                m_req_i[i] = 1'b1;  // hold until granted
            end else if (mask[i] && $urandom_range(99) < req_p) begin
                m_req_i[i]   = 1'b1;
                m_add_i[i]   = gen_addr(i);
                m_wen_i[i]   = 1'($urandom);
                m_wdata_i[i] = $urandom;
                m_be_i[i]    = BW'($urandom);
            end else begin
                m_req_i[i] = 1'b0;
            end
        end
        s_gnt_i = ($urandom_range(99) < gnt_p);
        if (l2_q.size() > 0 && $urandom_range(99) < rv_p) begin
            a           = l2_q.pop_front();
            s_r_valid_i = 1'b1;
            s_r_rdata_i = resp_data(a);
            s_r_opc_i   = 1'($urandom);
        end else begin
            s_r_valid_i = 1'b0;
            s_r_rdata_i = $urandom;
            s_r_opc_i   = 1'b0;
        end
    endtask

    task automatic drain();
        int c;
        mask  = '0;
        gnt_p = 100;
        rv_p  = 100;
        c     = 0;
        step();
        while (c < 60 && (l2_q.size() != 0 || m_req_i != '0)) begin
            step();
            c++;
        end
        chk("drain_timeout", 64'(c < 60), 64'd1);
        step();
        @(negedge clk);
        chk("drain_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int tally;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int tally;
        rst_i = 1'b1;
        m_req_i = '0; m_add_i = '0; m_wen_i = '0; m_wdata_i = '0; m_be_i = '0;
        s_gnt_i = 1'b0; s_r_valid_i = 1'b0; s_r_rdata_i = '0; s_r_opc_i = 1'b0;
        mask = '0; req_p = 0; gnt_p = 0; rv_p = 0;
        clear_model();
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_gnt", 64'(m_gnt_o), 64'd0);
        chk("reset_cnt0", 64'(grant_cnt_o[0]), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Grant counters: seven grants to master 0, then three to master 2.
        req_p = 100; gnt_p = 100; rv_p = 100;
        mask = 3'b001;
        repeat (7) step();
        mask = 3'b100;
        repeat (3) step();
        drain();
`ifdef FC_L2_ARB_PERF_EN
        chk("perf_cnt0", 64'(grant_cnt_o[0]), 64'd7);
        chk("perf_cnt1", 64'(grant_cnt_o[1]), 64'd0);
        chk("perf_cnt2", 64'(grant_cnt_o[2]), 64'd3);
`else
        chk("perf_cnt0", 64'(grant_cnt_o[0]), 64'd0);
        chk("perf_cnt1", 64'(grant_cnt_o[1]), 64'd0);
        chk("perf_cnt2", 64'(grant_cnt_o[2]), 64'd0);
`endif

        // Round robin with all three requesting continuously; pointer is back at 0 here.
        mask = 3'b111; req_p = 100; gnt_p = 100; rv_p = 100;
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            chk("rr_order", 64'(m_gnt_o), 64'(1 << (c % 3)));
        end
        drain();

        // Outstanding limit: no responses, exactly four grants.
        mask = 3'b111; req_p = 100; gnt_p = 100; rv_p = 0;
        tally = 0;
        repeat (6) begin
            step();
            @(negedge clk);
            tally += $countones(m_gnt_o);
        end
        chk("limit_grants", 64'(tally), 64'd4);
        chk("limit_sreq", 64'(s_req_o), 64'd0);
        rv_p = 100;
        step();
        @(negedge clk);
        chk("limit_full_grant", 64'($countones(m_gnt_o)), 64'd1);
        chk("limit_busy", 64'(busy_o), 64'd1);
        rv_p = 0;
        step();
        @(negedge clk);
        chk("limit_still_full", 64'(s_req_o), 64'd0);
        drain();

        // L2 stall: master 1 alone, gnt low for five cycles.
        @(posedge clk);
        #1;
        m_req_i = 3'b010;
        m_add_i[1] = 32'h1C00_0040;
        s_gnt_i = 1'b0;
        s_r_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_gnt", 64'(m_gnt_o), 64'd0);
            chk("stall_addr", 64'(s_add_o), 64'h1C00_0040);
            @(posedge clk);
            #1;
        end
        s_gnt_i = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'(m_gnt_o), 64'b010);
        @(posedge clk);
        #1;
        m_req_i = 3'b111;
        m_add_i[0] = 32'h1C00_0000;
        m_add_i[2] = 32'h1C00_0280;
        s_gnt_i = 1'b0;
        @(negedge clk);
        chk("stall_rr_next", 64'(s_add_o), 64'h1C00_0280);
        drain();

        // Randomised traffic.
        mask = 3'b111; req_p = 50; gnt_p = 70; rv_p = 40;
        repeat (300) step();
        drain();

        // Spurious response with nothing outstanding.
        @(posedge clk);
        #1;
        s_r_valid_i = 1'b1;
        s_r_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("spur_no_rvalid", 64'(m_r_valid_o), 64'd0);
        @(posedge clk);
        #1;
        s_r_valid_i = 1'b0;
        @(negedge clk);
        chk("spur_err", 64'(err_o), 64'd1);
        repeat (3) step();
        @(negedge clk);
        chk("spur_err_sticky", 64'(err_o), 64'd1);

        // Asynchronous reset with two transactions outstanding.
        mask = 3'b011; req_p = 100; gnt_p = 100; rv_p = 0;
        repeat (2) step();
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_err", 64'(err_o), 64'd0);
        chk("arst_gnt", 64'(m_gnt_o), 64'd0);
        clear_model();
        m_req_i = 3'b100;
        m_add_i[2] = 32'h1C00_0200;
        s_gnt_i = 1'b1;
        s_r_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("arst_first_gnt", 64'(m_gnt_o), 64'b100);
        drain();

        // More randomised traffic after reset.
        mask = 3'b111; req_p = 60; gnt_p = 60; rv_p = 50;
        repeat (150) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_l2_port_arbiter.md
Name: fc_l2_port_arbiter

Overview:
- Shares one L2 TCDM-style master port among N_MASTER requesters, e.g. FC core data port, debug or DMA helper, HWPE spill port.
- Round-robin arbitration with single-cycle req/gnt; tracks outstanding transactions in an ID FIFO and routes in-order responses back to the issuing requester.
- Sits between the FC subsystem's requesters and the l2_data_master bus.

Parameters:
- N_MASTER, 3, number of requester ports (2..8).
- MAX_OUTSTANDING, 4, max granted-but-unanswered transactions (power of 2, 2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- m_req_i  in  N_MASTER  per-requester request
- m_add_i  in  N_MASTER x ADDR_W  request address
- m_wen_i  in  N_MASTER  1 = read, 0 = write
- m_wdata_i  in  N_MASTER x DATA_W  write data
- m_be_i  in  N_MASTER x DATA_W/8  byte enables
- m_gnt_o  out  N_MASTER  grant, one-hot or zero
- m_r_valid_o  out  N_MASTER  response valid, one-hot or zero
- m_r_rdata_o  out  DATA_W  response data, broadcast
- m_r_opc_o  out  1  response error, broadcast
- s_req_o  out  1  L2 request
- s_add_o  out  ADDR_W  L2 address
- s_wen_o  out  1  L2 write-enable-n
- s_wdata_o  out  DATA_W  L2 write data
- s_be_o  out  DATA_W/8  L2 byte enables
- s_gnt_i  in  1  L2 grant
- s_r_valid_i  in  1  L2 response valid
- s_r_rdata_i  in  DATA_W  L2 read data
- s_r_opc_i  in  1  L2 response error
- busy_o  out  1  outstanding count != 0
- err_o  out  1  sticky protocol error
- grant_cnt_o  out  N_MASTER x 32  per-master grant counters (see Optional Feature)

Behaviour:
- Reset values: rr_ptr=0, FIFO empty, outstanding count=0, err_o=0, busy_o=0, all counters 0.
- Reset is asynchronous, including mid-transaction. Pending responses are forgotten; any later s_r_valid_i with an empty FIFO sets err_o.
- Arbitration is combinational.
  - Winner is the first asserted m_req_i at or after rr_ptr, scanning upward with wrap.
  - s_req_o = any request AND can_issue.
  - s_add/wen/wdata/be_o mux the winner's fields. They are 0 when there is no winner.
- can_issue = (count < MAX_OUTSTANDING) OR s_r_valid_i. When the FIFO is full, a same-cycle pop frees a slot.
- Grant: m_gnt_o[winner] = s_gnt_i & s_req_o, same cycle, zero added latency.
  - On a grant, winner index is pushed into the ID FIFO and rr_ptr <= winner+1 mod N_MASTER.
  - rr_ptr holds when there is no grant, including L2 gnt-low stalls. The same winner is retried until granted; a requester must hold req and fields stable until gnt.
- Response: on s_r_valid_i with FIFO non-empty:
  - m_r_valid_o[head] = 1 in the same cycle.
  - m_r_rdata_o = s_r_rdata_i, m_r_opc_o = s_r_opc_i, combinational.
  - FIFO pops.
- s_r_valid_i with FIFO empty: response dropped, err_o <= 1 (sticky until reset), no m_r_valid_o.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Responses from L2 are in order; out-of-order responses are unsupported.
- Minimum latency from gnt to r_valid is 1 cycle. The ID is written at the grant edge, so a response arriving in the next cycle finds it at the FIFO head.
- busy_o registered = (count != 0).

Optional Feature:
- Macro FC_L2_ARB_PERF_EN.
- Defined: grant_cnt_o[i] increments by 1 on each m_gnt_o[i] and saturates at 0xFFFFFFFF. Reset to 0.
- Undefined: no counter flops; grant_cnt_o is tied to 0.

Decomposition:
- Package fc_l2_arb_pkg holds:
  - typedef id_t = logic [$clog2(N_MASTER_MAX=8)-1:0]
  - localparam CNT_W=32
  - function rr_pick(req, ptr) returning winner and valid.
- Sub-module fc_l2_arb_id_fifo: parameterised-depth FIFO of id_t with push, pop, head, count, full and empty. Supports same-cycle push and pop when full.
- The top instantiates the FIFO and holds the rr pointer, muxes and error logic.

Test Plan:
- Round robin: all 3 masters request continuously, s_gnt_i=1, r_valid 1 cycle later → grant order 0,1,2,0,1,2. Each m_r_valid_o one-hot matches the issuer one cycle after gnt. Data 0xA0+i is returned to master i.
- Outstanding limit: 3 masters request, s_gnt_i=1, no responses → exactly 4 grants, then s_req_o=0. Assert s_r_valid_i → a 5th grant happens in the same cycle (push+pop while full) and count stays at 4.
- L2 stall: master 1 alone requests, s_gnt_i=0 for 5 cycles then 1 → m_gnt_o=0 for 5 cycles, then 010b. rr_ptr goes to 2 only after the grant. Address 0x1C00_0040 is stable on s_add_o throughout.
- Spurious response: s_r_valid_i pulse with no outstanding → err_o=1 next cycle and stays 1. No m_r_valid_o.
- Reset mid-op: 2 outstanding, assert rst_i asynchronously → busy_o, err_o and m_gnt_o read 0 immediately. After release, a fresh request by master 2 is granted first (rr_ptr=0 scan).
- With FC_L2_ARB_PERF_EN: 7 grants to master 0 and 3 to master 2 → grant_cnt_o = {3,0,7}. Without the macro, all counters read 0.
